// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the dmem arbitration logic: FSM encoding,
// read-owner encoding and the default starvation limit.
package mem_ctrl_pkg;

  localparam int STARVE_LIMIT_DEFAULT = 4;
  localparam int STARVE_CNT_W         = 4;

  typedef enum logic {
    PROC_PRI  = 1'b0,
    EXT_FORCE = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWNER_PROC = 1'b0,
    OWNER_EXT  = 1'b1
  } owner_t;

endpackage

// File: rtl/starve_counter.sv
// Counts consecutive cycles in which the external port is denied;
// saturates at LIMIT and flags when the limit is reached.
module starve_counter
  import mem_ctrl_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_V = LIMIT[STARVE_CNT_W-1:0];

  logic [STARVE_CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign limit_hit = (cnt == LIMIT_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port dmem arbiter: the processor has priority, but the external
// port is given one forced grant after STARVE_LIMIT denied cycles.
module dmem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int ADDR_W       = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              proc_req,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [31:0]       proc_data,
  input  logic              proc_wren,
  output logic              proc_gnt,
  output logic              proc_rvalid,
  output logic [31:0]       proc_q,
  input  logic              ext_req,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [31:0]       ext_data,
  input  logic              ext_wren,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [31:0]       ext_q,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [31:0]       data,
  output logic              wren,
  input  logic [31:0]       q_dmem
);

  arb_state_t        state, state_next;
  owner_t            owner;
  logic              rd_pending;
  logic [ADDR_W-1:0] last_addr;
  logic              limit_hit;
  logic              any_gnt;

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clock     (clock),
    .reset     (reset),
    .inc       (ext_req & ~ext_gnt),
    .clr       (ext_gnt | ~ext_req),
    .limit_hit (limit_hit)
  );

  // Grants are suppressed during reset; the forced state lasts one cycle.
  always_comb begin
    proc_gnt   = 1'b0;
    ext_gnt    = 1'b0;
    state_next = PROC_PRI;
    if (!reset) begin
      case (state)
        PROC_PRI: begin
          if (proc_req)     proc_gnt = 1'b1;
          else if (ext_req) ext_gnt  = 1'b1;
        end
        EXT_FORCE: begin
          if (ext_req)       ext_gnt  = 1'b1;
          else if (proc_req) proc_gnt = 1'b1;
        end
        default: ;
      endcase
      if (state == PROC_PRI && limit_hit && !ext_gnt) state_next = EXT_FORCE;
    end
  end

  assign any_gnt = proc_gnt | ext_gnt;

  always_comb begin
    address_dmem = last_addr;
    data         = proc_data;
    wren         = 1'b0;
    if (proc_gnt) begin
      address_dmem = proc_addr;
      data         = proc_data;
      wren         = proc_wren;
    end else if (ext_gnt) begin
      address_dmem = ext_addr;
      data         = ext_data;
      wren         = ext_wren;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= PROC_PRI;
      last_addr  <= '0;
      owner      <= OWNER_PROC;
      rd_pending <= 1'b0;
    end else begin
      state      <= state_next;
      rd_pending <= any_gnt & ~wren;
      if (any_gnt) begin
        last_addr <= address_dmem;
        owner     <= ext_gnt ? OWNER_EXT : OWNER_PROC;
      end
    end
  end

  // Gating with reset kills a read whose data would land during reset.
  assign proc_rvalid = rd_pending && (owner == OWNER_PROC) && !reset;
  assign ext_rvalid  = rd_pending && (owner == OWNER_EXT) && !reset;
  assign proc_q      = q_dmem;
  assign ext_q       = q_dmem;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus hand-written
// starvation/idle/reset sequences, read data checked through a scoreboard.
module tb_dmem_arbiter;
  import mem_ctrl_pkg::*;

  localparam int ADDR_W = 12;

  logic              clock = 1'b0;
  logic              reset;
  logic              proc_req, proc_wren, proc_gnt, proc_rvalid;
  logic [ADDR_W-1:0] proc_addr;
  logic [31:0]       proc_data, proc_q;
  logic              ext_req, ext_wren, ext_gnt, ext_rvalid;
  logic [ADDR_W-1:0] ext_addr;
  logic [31:0]       ext_data, ext_q;
  logic [ADDR_W-1:0] address_dmem;
  logic [31:0]       data, q_dmem;
  logic              wren;

  dmem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(ADDR_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .proc_req     (proc_req),
    .proc_addr    (proc_addr),
    .proc_data    (proc_data),
    .proc_wren    (proc_wren),
    .proc_gnt     (proc_gnt),
    .proc_rvalid  (proc_rvalid),
    .proc_q       (proc_q),
    .ext_req      (ext_req),
    .ext_addr     (ext_addr),
    .ext_data     (ext_data),
    .ext_wren     (ext_wren),
    .ext_gnt      (ext_gnt),
    .ext_rvalid   (ext_rvalid),
    .ext_q        (ext_q),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [0:4095];
  always @(posedge clock) begin
    if (wren) mem[address_dmem] <= data;
    q_dmem <= mem[address_dmem];
  end

  typedef struct packed {
    logic              preq;
    logic [ADDR_W-1:0] paddr;
    logic              pwren;
    logic [31:0]       pdata;
    logic              ereq;
    logic [ADDR_W-1:0] eaddr;
    logic              ewren;
    logic [31:0]       edata;
    logic              exp_pg;
    logic              exp_eg;
  } vec_t;

  typedef struct packed {
    logic        prv;
    logic        erv;
    logic [31:0] q;
  } sb_t;

  vec_t              vecs [10];
  sb_t               sbq [$];
  logic [31:0]       ref_mem [0:4095];
  logic [ADDR_W-1:0] exp_last;
  int                total = 0;
  int                bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    proc_req  = v.preq;  proc_addr = v.paddr; proc_wren = v.pwren; proc_data = v.pdata;
    ext_req   = v.ereq;  ext_addr  = v.eaddr; ext_wren  = v.ewren; ext_data  = v.edata;
  endtask

  task automatic checkOutput(input vec_t v);
    sb_t               e, n;
    logic [ADDR_W-1:0] a;
    logic              w;
    logic [31:0]       d;
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
      e = '0;
    end else begin
      e = sbq.pop_front();
    end
    check("proc_rvalid", {31'b0, proc_rvalid}, {31'b0, e.prv});
    check("ext_rvalid", {31'b0, ext_rvalid}, {31'b0, e.erv});
    if (e.prv) check("proc_q", proc_q, e.q);
    if (e.erv) check("ext_q", ext_q, e.q);
    check("proc_gnt", {31'b0, proc_gnt}, {31'b0, v.exp_pg});
    check("ext_gnt", {31'b0, ext_gnt}, {31'b0, v.exp_eg});
    if (v.exp_pg)      begin a = v.paddr; w = v.pwren; d = v.pdata; end
    else if (v.exp_eg) begin a = v.eaddr; w = v.ewren; d = v.edata; end
    else               begin a = exp_last; w = 1'b0; d = '0; end
    check("address_dmem", {20'b0, address_dmem}, {20'b0, a});
    check("wren", {31'b0, wren}, {31'b0, w});
    if (w) check("data", data, d);
    n.prv = v.exp_pg & ~v.pwren;
    n.erv = v.exp_eg & ~v.ewren;
    n.q   = ref_mem[a];
    sbq.push_back(n);
    if (w) ref_mem[a] = d;
    if (v.exp_pg || v.exp_eg) exp_last = a;
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    #5;
    checkOutput(v);
    @(posedge clock);
    #1;
  endtask

  task automatic doReset(input int n);
    reset = 1'b1;
    applyStimulus('0);
    for (int i = 0; i < n; i++) begin
      #5;
      check("rst proc_gnt", {31'b0, proc_gnt}, 32'd0);
      check("rst ext_gnt", {31'b0, ext_gnt}, 32'd0);
      check("rst wren", {31'b0, wren}, 32'd0);
      check("rst proc_rvalid", {31'b0, proc_rvalid}, 32'd0);
      check("rst ext_rvalid", {31'b0, ext_rvalid}, 32'd0);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    sbq.delete();
    sbq.push_back('0);
    exp_last = '0;
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 32'hA5000000 ^ (i * 32'h00010003);
      ref_mem[i] = 32'hA5000000 ^ (i * 32'h00010003);
    end
    mem[12'h010]     = 32'h12345678;
    ref_mem[12'h010] = 32'h12345678;

    vecs[0] = '{1'b1, 12'h010, 1'b0, 32'h0,        1'b0, 12'h000, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[1] = '{1'b0, 12'h000, 1'b0, 32'h0,        1'b1, 12'h7FF, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 12'h7FF, 1'b0, 32'h0,        1'b0, 12'h000, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[3] = '{1'b1, 12'h020, 1'b0, 32'h0,        1'b0, 12'h000, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[4] = '{1'b0, 12'h000, 1'b0, 32'h0,        1'b1, 12'h030, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[5] = '{1'b1, 12'h040, 1'b1, 32'hCAFEF00D, 1'b1, 12'h050, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[6] = '{1'b0, 12'h000, 1'b0, 32'h0,        1'b1, 12'h040, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[7] = '{1'b0, 12'h000, 1'b0, 32'h0,        1'b0, 12'h000, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[8] = '{1'b1, 12'h040, 1'b0, 32'h0,        1'b1, 12'h060, 1'b1, 32'h00000001, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 12'h000, 1'b0, 32'h0,        1'b0, 12'h000, 1'b0, 32'h0,        1'b0, 1'b0};

    reset = 1'b1;
    applyStimulus('0);
    @(posedge clock);
    #1;
    doReset(2);

    for (int i = 0; i < 10; i++) runVec(vecs[i]);

    for (int i = 0; i < 10; i++) runVec('0);

    doReset(1);
    for (int c = 1; c <= 18; c++) begin
      v        = '0;
      v.preq   = 1'b1;
      v.paddr  = ADDR_W'(c);
      v.ereq   = 1'b1;
      v.eaddr  = ADDR_W'(12'h100 + c);
      v.exp_eg = (c % 6 == 0);
      v.exp_pg = !v.exp_eg;
      runVec(v);
    end

    // Ext read granted, then reset arrives before its data returns.
    v        = '0;
    v.ereq   = 1'b1;
    v.eaddr  = 12'h0AB;
    v.exp_eg = 1'b1;
    runVec(v);
    doReset(1);
    v        = '0;
    v.preq   = 1'b1;
    v.paddr  = 12'h0AC;
    v.ereq   = 1'b1;
    v.eaddr  = 12'h0AD;
    v.exp_pg = 1'b1;
    runVec(v);
    runVec('0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive denied external-request cycles before the external port is forced a grant; legal range 1..15.
REQ-002 Parameter ADDR_W, default 12: dmem word-address width.
REQ-003 clock  in  1  single clock for the block; reset is synchronous and active-high.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 proc_req  in  1  processor requests a dmem access this cycle.
REQ-006 proc_addr  in  ADDR_W  processor access address.
REQ-007 proc_data  in  32  processor write data.
REQ-008 proc_wren  in  1  processor write enable; qualified by proc_req.
REQ-009 proc_gnt  out  1  processor access accepted this cycle; processor stalls when proc_req=1 and proc_gnt=0.
REQ-010 proc_rvalid  out  1  proc_q holds data from the processor read granted one cycle earlier.
REQ-011 proc_q  out  32  processor read data.
REQ-012 ext_req, ext_addr[ADDR_W], ext_data[32], ext_wren  in  external loader/debug port request signals, same meaning as the proc_* inputs.
REQ-013 ext_gnt, ext_rvalid  out  1  external grant and external read-data valid.
REQ-014 ext_q  out  32  external read data.
REQ-015 address_dmem  out  ADDR_W  dmem address.
REQ-016 data  out  32  dmem write data.
REQ-017 wren  out  1  dmem write enable.
REQ-018 q_dmem  in  32  dmem read data, valid one cycle after the address.

Function
REQ-019 FSM states: PROC_PRI (processor has priority) and EXT_FORCE (external port forced); each arbitration decision is made combinationally from the current state, the requests and the starvation counter.
REQ-020 In PROC_PRI: if proc_req=1, grant the processor; else if ext_req=1, grant the external port; else grant neither.
REQ-021 starve_cnt (4 bits) increments each cycle that ext_req=1 and ext_gnt=0, clears when ext_gnt=1 or ext_req=0, and saturates at STARVE_LIMIT.
REQ-022 When starve_cnt reaches STARVE_LIMIT, the FSM moves to EXT_FORCE on the next edge.
REQ-023 In EXT_FORCE: ext_gnt=1 when ext_req=1 and proc_gnt=0; the FSM returns to PROC_PRI on the next edge, so exactly one forced grant is given.
REQ-024 If ext_req drops while in EXT_FORCE, grant the processor when proc_req=1 and return to PROC_PRI.
REQ-025 proc_gnt and ext_gnt are never both 1.
REQ-026 Muxing: address_dmem, data and wren come from the granted port; wren=granted_wren & gnt; with no grant, address_dmem holds its last value and wren=0.
REQ-027 A read (gnt=1, wren=0) sets the owner's rvalid=1 exactly one cycle later, with the owner's q equal to q_dmem.
REQ-028 rvalid is not asserted for writes.
REQ-029 proc_q and ext_q both drive q_dmem; only rvalid marks ownership.
REQ-030 Back-to-back grants to alternating ports are legal, and each port's rvalid follows its own grant.
REQ-031 Grant latency is zero cycles; read-data latency is one cycle; throughput is one access per cycle.

Reset
REQ-032 On reset, the FSM goes to PROC_PRI, starve_cnt=0, proc_rvalid=ext_rvalid=0, the registered last address=0 and the owner register=processor.
REQ-033 Grant outputs are forced to 0 and wren=0 while reset=1.
REQ-034 A read granted in the cycle before reset asserts produces no rvalid.

Structure
REQ-035 The FSM state encoding and the STARVE_LIMIT default belong in the shared package mem_ctrl_pkg.
REQ-036 The starvation counter is the sub-module starve_counter (increment, clear, saturate, limit-hit output); everything else is flat.

Verification
REQ-037 Reset, then proc_req=1 read at addr 0x010 with dmem preloaded 0x12345678 -> proc_gnt=1 the same cycle, proc_rvalid=1 and proc_q=0x12345678 the next cycle.
REQ-038 proc_req and ext_req held at 1 continuously, STARVE_LIMIT=4 -> ext_gnt=1 on cycle 6 only (4 denied cycles, FSM transition, forced grant), then the pattern repeats every 6 cycles.
REQ-039 ext write 0xDEADBEEF to 0x7FF with the processor idle, then processor read of 0x7FF -> ext_gnt the same cycle, wren=1 for one cycle, and the processor read returns 0xDEADBEEF with ext_rvalid=0 throughout.
REQ-040 Both idle for 10 cycles -> wren=0, both gnt=0, starve_cnt=0 and address_dmem unchanged.
REQ-041 Reset asserted the cycle after an ext read grant -> ext_rvalid stays 0 and the FSM is in PROC_PRI after reset.
REQ-042 Alternate grants proc read A then ext read B on consecutive cycles -> proc_rvalid then ext_rvalid on consecutive cycles, each carrying its own address's data.
